// File: rtl/axi_line_master_if.sv
// axi_line_master_if: AXI4 bus between the line master and its slave.
// Latency: none, wires only.
// Backpressure: standard AXI4 valid/ready on all five channels.
// Ports: mst_aw*/mst_w*/mst_b*/mst_ar*/mst_r*; modport master drives requests, slave drives responses.
interface axi_line_master_if #(
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     mst_awid;
    logic [ADDR_W-1:0]   mst_awaddr;
    logic [7:0]          mst_awlen;
    logic [2:0]          mst_awsize;
    logic [1:0]          mst_awburst;
    logic                mst_awlock;
    logic [3:0]          mst_awcache;
    logic [2:0]          mst_awprot;
    logic [3:0]          mst_awqos;
    logic [3:0]          mst_awregion;
    logic                mst_awvalid;
    logic                mst_awready;

    logic [DATA_W-1:0]   mst_wdata;
    logic [DATA_W/8-1:0] mst_wstrb;
    logic                mst_wlast;
    logic                mst_wvalid;
    logic                mst_wready;

    logic [ID_W-1:0]     mst_bid;
    logic [1:0]          mst_bresp;
    logic                mst_bvalid;
    logic                mst_bready;

    logic [ID_W-1:0]     mst_arid;
    logic [ADDR_W-1:0]   mst_araddr;
    logic [7:0]          mst_arlen;
    logic [2:0]          mst_arsize;
    logic [1:0]          mst_arburst;
    logic                mst_arlock;
    logic [3:0]          mst_arcache;
    logic [2:0]          mst_arprot;
    logic [3:0]          mst_arqos;
    logic [3:0]          mst_arregion;
    logic                mst_arvalid;
    logic                mst_arready;

    logic [ID_W-1:0]     mst_rid;
    logic [DATA_W-1:0]   mst_rdata;
    logic [1:0]          mst_rresp;
    logic                mst_rlast;
    logic                mst_rvalid;
    logic                mst_rready;

    modport master (
        output mst_awid, mst_awaddr, mst_awlen, mst_awsize, mst_awburst, mst_awlock,
               mst_awcache, mst_awprot, mst_awqos, mst_awregion, mst_awvalid,
        input  mst_awready,
        output mst_wdata, mst_wstrb, mst_wlast, mst_wvalid,
        input  mst_wready,
        input  mst_bid, mst_bresp, mst_bvalid,
        output mst_bready,
        output mst_arid, mst_araddr, mst_arlen, mst_arsize, mst_arburst, mst_arlock,
               mst_arcache, mst_arprot, mst_arqos, mst_arregion, mst_arvalid,
        input  mst_arready,
        input  mst_rid, mst_rdata, mst_rresp, mst_rlast, mst_rvalid,
        output mst_rready
    );

    modport slave (
        input  mst_awid, mst_awaddr, mst_awlen, mst_awsize, mst_awburst, mst_awlock,
               mst_awcache, mst_awprot, mst_awqos, mst_awregion, mst_awvalid,
        output mst_awready,
        input  mst_wdata, mst_wstrb, mst_wlast, mst_wvalid,
        output mst_wready,
        output mst_bid, mst_bresp, mst_bvalid,
        input  mst_bready,
        input  mst_arid, mst_araddr, mst_arlen, mst_arsize, mst_arburst, mst_arlock,
               mst_arcache, mst_arprot, mst_arqos, mst_arregion, mst_arvalid,
        output mst_arready,
        output mst_rid, mst_rdata, mst_rresp, mst_rlast, mst_rvalid,
        input  mst_rready
    );
endinterface

// File: rtl/axi_line_master.sv
// axi_line_master: moves one cache line (refill or writeback) as a single AXI4 INCR burst.
// Latency: one cycle per handshake, no bubbles; next request accepted the cycle after rsp_valid.
// Backpressure: req_ready only in IDLE; every AXI valid holds with stable payload until ready.
// Ports: aclk, arst_n (async, active-low); req_* line request; rsp_* one-cycle completion;
//        axi (axi_line_master_if.master) AXI4 master bus.
// Option: define AXI_LINE_MASTER_RESP_CHECK_EN to report rresp/bresp/rlast errors on rsp_err.
module axi_line_master #(
    parameter int          AXI_ADDR_W = 64,
    parameter int          AXI_ID_W   = 8,
    parameter int          AXI_DATA_W = 64,
    parameter int          LINE_BEATS = 4,
    parameter int unsigned MST_ID     = 0
) (
    input  logic                             aclk,
    input  logic                             arst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [AXI_ADDR_W-1:0]            req_addr,
    input  logic [LINE_BEATS*AXI_DATA_W-1:0] req_wdata,
    output logic                             rsp_valid,
    output logic [LINE_BEATS*AXI_DATA_W-1:0] rsp_rdata,
    output logic                             rsp_err,
    axi_line_master_if.master                axi
);
    localparam int LINE_W = LINE_BEATS * AXI_DATA_W;
    localparam int OFS_W  = $clog2(LINE_BEATS * 8);
    localparam int CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = {AXI_ADDR_W{1'b1}} << OFS_W;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RSP} state_t;

    state_t                  state_q;
    logic [AXI_ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]       line_q;      // write line, reused as refill assembly buffer
    logic [LINE_W-1:0]       rdata_q;     // last completed refill, untouched by writebacks
    logic [LINE_W-1:0]       line_merged;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ar_vld_q, r_rdy_q, aw_vld_q, w_vld_q, b_rdy_q, rsp_vld_q;
    logic                    cnt_mismatch;
    logic                    unused_in;

    // Current R beat merged into the line, so the final beat can be committed
    // to rsp_rdata in the same cycle it arrives.
    always_comb begin
        line_merged = line_q;
        line_merged[cnt_q*AXI_DATA_W +: AXI_DATA_W] = axi.mst_rdata;
    end

    // rlast must coincide exactly with the last slot of the line.
    assign cnt_mismatch = axi.mst_rlast != (cnt_q == LAST_BEAT);

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            line_q    <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            ar_vld_q  <= 1'b0;
            r_rdy_q   <= 1'b0;
            aw_vld_q  <= 1'b0;
            w_vld_q   <= 1'b0;
            b_rdy_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    addr_q <= req_addr & ADDR_MASK;
                    line_q <= req_wdata;
                    cnt_q  <= '0;
                    if (req_write) begin
                        state_q  <= AW;
                        aw_vld_q <= 1'b1;
                    end else begin
                        state_q  <= AR;
                        ar_vld_q <= 1'b1;
                    end
                end
                AR: if (axi.mst_arready) begin
                    ar_vld_q <= 1'b0;
                    r_rdy_q  <= 1'b1;
                    state_q  <= R;
                end
                R: if (axi.mst_rvalid) begin
                    line_q <= line_merged;
                    if (axi.mst_rlast) begin
                        rdata_q   <= line_merged;
                        r_rdy_q   <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RSP;
                    end else if (cnt_q != LAST_BEAT) begin
                        // Saturate: surplus beats land in the last slot and are flagged.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                AW: if (axi.mst_awready) begin
                    aw_vld_q <= 1'b0;
                    w_vld_q  <= 1'b1;
                    state_q  <= W;
                end
                W: if (axi.mst_wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        w_vld_q <= 1'b0;
                        b_rdy_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= B;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                B: if (axi.mst_bvalid) begin
                    b_rdy_q   <= 1'b0;
                    rsp_vld_q <= 1'b1;
                    state_q   <= RSP;
                end
                RSP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_LINE_MASTER_RESP_CHECK_EN
    logic err_q;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && req_valid) begin
            err_q <= 1'b0;
        end else if (state_q == R && axi.mst_rvalid &&
                     (axi.mst_rresp != 2'b00 || cnt_mismatch)) begin
            err_q <= 1'b1;
        end else if (state_q == B && axi.mst_bvalid && axi.mst_bresp != 2'b00) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign unused_in = ^{axi.mst_rid, axi.mst_bid, axi.mst_rresp, axi.mst_bresp, cnt_mismatch};

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_vld_q;
    assign rsp_rdata = rdata_q;

    assign axi.mst_awid     = AXI_ID_W'(MST_ID);
    assign axi.mst_awaddr   = addr_q;
    assign axi.mst_awlen    = 8'(LINE_BEATS - 1);
    assign axi.mst_awsize   = 3'd3;
    assign axi.mst_awburst  = 2'b01;
    assign axi.mst_awlock   = 1'b0;
    assign axi.mst_awcache  = 4'h0;
    assign axi.mst_awprot   = 3'h0;
    assign axi.mst_awqos    = 4'h0;
    assign axi.mst_awregion = 4'h0;
    assign axi.mst_awvalid  = aw_vld_q;

    assign axi.mst_wdata    = line_q[cnt_q*AXI_DATA_W +: AXI_DATA_W];
    assign axi.mst_wstrb    = {(AXI_DATA_W/8){1'b1}};
    assign axi.mst_wlast    = w_vld_q && (cnt_q == LAST_BEAT);
    assign axi.mst_wvalid   = w_vld_q;
    assign axi.mst_bready   = b_rdy_q;

    assign axi.mst_arid     = AXI_ID_W'(MST_ID);
    assign axi.mst_araddr   = addr_q;
    assign axi.mst_arlen    = 8'(LINE_BEATS - 1);
    assign axi.mst_arsize   = 3'd3;
    assign axi.mst_arburst  = 2'b01;
    assign axi.mst_arlock   = 1'b0;
    assign axi.mst_arcache  = 4'h0;
    assign axi.mst_arprot   = 3'h0;
    assign axi.mst_arqos    = 4'h0;
    assign axi.mst_arregion = 4'h0;
    assign axi.mst_arvalid  = ar_vld_q;
    assign axi.mst_rready   = r_rdy_q;
endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master: directed vector table driven through a cycle-level AXI slave model.
// Covers refill/writeback, stalls, response errors (AXI_LINE_MASTER_RESP_CHECK_EN), reset mid-burst.
// Inputs driven and outputs sampled on the falling edge of aclk.
`timescale 1ns/1ps
module tb_axi_line_master;
    localparam int AW = 64, IW = 8, DW = 64, LB = 4;
`ifdef AXI_LINE_MASTER_RESP_CHECK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              arst_n;
    logic              req_valid, req_ready, req_write;
    logic [AW-1:0]     req_addr;
    logic [LB*64-1:0]  req_wdata;
    logic              rsp_valid, rsp_err;
    logic [LB*64-1:0]  rsp_rdata;

    always #5 aclk = ~aclk;

    axi_line_master_if #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) axi ();

    axi_line_master #(
        .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW), .LINE_BEATS(LB), .MST_ID(5)
    ) dut (
        .aclk(aclk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi(axi.master)
    );

    typedef struct {
        bit           wr;
        logic [63:0]  addr;
        logic [63:0]  exp_addr;
        logic [255:0] line;       // refill beats returned, or writeback data
        bit           stall;
        int           rresp_beat; // beat carrying SLVERR, -1 for none
        bit           bresp_err;
        bit           inj_err;
        int           exp_lat;    // falling edges from accept to rsp_valid, -1 = unchecked
    } vec_t;

    int n_pass = 0, n_total = 0;
    logic [255:0] last_refill = '0;

    task automatic chk(input string name, input int idx, input logic [255:0] act,
                       input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
    endtask

    task automatic slave_idle();
        axi.mst_awready = 0; axi.mst_wready = 0; axi.mst_arready = 0;
        axi.mst_bid = '0; axi.mst_bresp = 2'b00; axi.mst_bvalid = 0;
        axi.mst_rid = '0; axi.mst_rdata = '0; axi.mst_rresp = 2'b00;
        axi.mst_rlast = 0; axi.mst_rvalid = 0;
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge
    // after RSP so the next call issues its request back-to-back.
    task automatic run_vec(input int idx, input vec_t v);
        int r_idx = 0, w_idx = 0, n_rsp = 0, lat = -1, w_bad = 0, n_ar = 0, n_aw = 0;
        bit ar_hs = 0, aw_hs = 0, b_done = 0, r_hs = 0, b_hs = 0, done = 0;
        bit overlap = 0, unstable = 0, early_w = 0, w_hold = 0, idle_after = 0;
        logic [63:0]  a_addr = '0, w_hold_dat = '0;
        logic [12:0]  a_misc = '0;
        logic [7:0]   a_len = '0;
        logic [255:0] got_rd = '0;
        logic         got_err = 0;
        chk("req_ready_idle", idx, req_ready, 1);
        req_valid = 1; req_write = v.wr; req_addr = v.addr;
        req_wdata = v.wr ? v.line : '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge aclk);
            req_valid = 0;
            if (axi.mst_arvalid && axi.mst_awvalid) overlap = 1;
            if (rsp_valid) begin
                n_rsp++;
                if (lat < 0) lat = cyc;
                got_rd = rsp_rdata; got_err = rsp_err;
            end else if (n_rsp > 0) begin
                idle_after = req_ready; done = 1;
            end
            // R channel
            if (ar_hs && r_idx < LB) begin
                if (!axi.mst_rvalid || r_hs)
                    axi.mst_rvalid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                axi.mst_rdata = v.line[r_idx*64 +: 64];
                axi.mst_rresp = (r_idx == v.rresp_beat) ? 2'b10 : 2'b00;
                axi.mst_rlast = (r_idx == LB - 1);
                axi.mst_rid   = 8'd5;
                r_hs = axi.mst_rvalid && axi.mst_rready;
                if (r_hs) r_idx++;
            end else begin
                axi.mst_rvalid = 0; axi.mst_rlast = 0; r_hs = 0;
            end
            // AR channel
            if (axi.mst_arvalid) begin
                if (n_ar == 0 && !ar_hs && a_len == 0 && a_addr == 0) begin
                    a_addr = axi.mst_araddr; a_len = axi.mst_arlen;
                    a_misc = {axi.mst_arsize, axi.mst_arburst, axi.mst_arid};
                end else if (axi.mst_araddr != a_addr) unstable = 1;
                axi.mst_arready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.mst_arready) begin ar_hs = 1; n_ar++; end
            end else axi.mst_arready = 0;
            // B channel
            if (w_idx == LB && !b_done) begin
                if (!axi.mst_bvalid || b_hs)
                    axi.mst_bvalid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                axi.mst_bresp = v.bresp_err ? 2'b10 : 2'b00;
                axi.mst_bid   = 8'd5;
                b_hs = axi.mst_bvalid && axi.mst_bready;
                if (b_hs) b_done = 1;
            end else begin
                axi.mst_bvalid = 0; b_hs = 0;
            end
            // W channel
            if (axi.mst_wvalid) begin
                if (!aw_hs) early_w = 1;
                if (w_hold && axi.mst_wdata != w_hold_dat) unstable = 1;
                axi.mst_wready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.mst_wready) begin
                    if (w_idx >= LB) w_bad++;
                    else if (axi.mst_wdata != v.line[w_idx*64 +: 64]) w_bad++;
                    if (axi.mst_wlast != (w_idx == LB - 1)) w_bad++;
                    if (axi.mst_wstrb != 8'hFF) w_bad++;
                    w_idx++; w_hold = 0;
                end else begin
                    w_hold = 1; w_hold_dat = axi.mst_wdata;
                end
            end else begin
                axi.mst_wready = 0; w_hold = 0;
                if (axi.mst_wlast) w_bad++;
            end
            // AW channel
            if (axi.mst_awvalid) begin
                if (n_aw == 0 && !aw_hs && a_len == 0 && a_addr == 0) begin
                    a_addr = axi.mst_awaddr; a_len = axi.mst_awlen;
                    a_misc = {axi.mst_awsize, axi.mst_awburst, axi.mst_awid};
                end else if (axi.mst_awaddr != a_addr) unstable = 1;
                axi.mst_awready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.mst_awready) begin aw_hs = 1; n_aw++; end
            end else axi.mst_awready = 0;
        end
        chk("completed", idx, done, 1);
        chk("rsp_pulses", idx, n_rsp, 1);
        chk("ready_after_rsp", idx, idle_after, 1);
        chk("ar_aw_overlap", idx, overlap, 0);
        chk("payload_stable", idx, unstable, 0);
        chk("addr", idx, a_addr, v.exp_addr);
        chk("len", idx, a_len, 3);
        chk("size_burst_id", idx, a_misc, {3'd3, 2'b01, 8'd5});
        chk("rsp_err", idx, got_err, RESP_CHK & v.inj_err);
        if (v.exp_lat >= 0) chk("latency", idx, lat, v.exp_lat);
        if (v.wr) begin
            chk("aw_count", idx, {n_aw, n_ar}, {32'd1, 32'd0});
            chk("w_beats", idx, w_idx, LB);
            chk("w_errors", idx, w_bad, 0);
            chk("w_before_aw", idx, early_w, 0);
            chk("rdata_held", idx, got_rd, last_refill);
        end else begin
            chk("ar_count", idx, {n_ar, n_aw}, {32'd1, 32'd0});
            chk("r_beats", idx, r_idx, LB);
            chk("rdata", idx, got_rd, v.line);
            last_refill = v.line;
        end
    endtask

    localparam logic [255:0] L0 = {64'h44, 64'h33, 64'h22, 64'h11};
    localparam logic [255:0] LW = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444,
                                   64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    localparam logic [255:0] L2 = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                                   64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};

    initial begin
        vec_t vecs[9];
        bit   spurious;
        vecs[0] = '{wr:0, addr:64'h8000_0013, exp_addr:64'h8000_0000, line:L0, stall:0,
                    rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:5};
        vecs[1] = '{wr:1, addr:64'h8000_0100, exp_addr:64'h8000_0100, line:LW, stall:0,
                    rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:6};
        vecs[2] = '{wr:0, addr:64'h1234_567F, exp_addr:64'h1234_5660, line:L2, stall:0,
                    rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:5};
        vecs[3] = '{wr:0, addr:64'hFFFF_FFFF_FFFF_FFFF, exp_addr:64'hFFFF_FFFF_FFFF_FFE0,
                    line:L0, stall:1, rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:-1};
        vecs[4] = '{wr:1, addr:64'h0000_001F, exp_addr:64'h0, line:LW, stall:1,
                    rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:-1};
        vecs[5] = '{wr:0, addr:64'h2000, exp_addr:64'h2000, line:L2, stall:0,
                    rresp_beat:2, bresp_err:0, inj_err:1, exp_lat:5};
        vecs[6] = '{wr:0, addr:64'h2008, exp_addr:64'h2000, line:L0, stall:0,
                    rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:5};
        vecs[7] = '{wr:1, addr:64'h3000, exp_addr:64'h3000, line:LW, stall:0,
                    rresp_beat:-1, bresp_err:1, inj_err:1, exp_lat:6};
        vecs[8] = '{wr:1, addr:64'h3020, exp_addr:64'h3020, line:LW, stall:1,
                    rresp_beat:-1, bresp_err:0, inj_err:0, exp_lat:-1};

        arst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        slave_idle();
        repeat (3) @(negedge aclk);
        chk("reset_req_ready", -1, req_ready, 1);
        chk("reset_valids", -1, {axi.mst_arvalid, axi.mst_awvalid, axi.mst_wvalid,
            axi.mst_wlast, axi.mst_rready, axi.mst_bready, rsp_valid}, 0);
        chk("reset_rsp", -1, {rsp_err, rsp_rdata}, 0);
        chk("reset_addr", -1, {axi.mst_araddr, axi.mst_awaddr}, 0);
        chk("tied_zero", -1, {axi.mst_awlock, axi.mst_awcache, axi.mst_awprot, axi.mst_awqos,
            axi.mst_awregion, axi.mst_arlock, axi.mst_arcache, axi.mst_arprot,
            axi.mst_arqos, axi.mst_arregion}, 0);
        arst_n = 1;
        @(negedge aclk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset while W beat 1 is on the bus.
        req_valid = 1; req_write = 1; req_addr = 64'h40; req_wdata = LW;
        @(negedge aclk);
        req_valid = 0; axi.mst_awready = 1;
        @(negedge aclk);
        axi.mst_awready = 0;
        chk("rst_w_beat0", 9, {axi.mst_wvalid, axi.mst_wdata}, {1'b1, LW[63:0]});
        axi.mst_wready = 1;
        @(negedge aclk);
        axi.mst_wready = 0;
        chk("rst_w_beat1", 9, {axi.mst_wvalid, axi.mst_wdata}, {1'b1, LW[127:64]});
        arst_n = 0;
        #1;
        chk("rst_valids_low", 9, {axi.mst_arvalid, axi.mst_awvalid, axi.mst_wvalid,
            axi.mst_wlast, axi.mst_rready, axi.mst_bready, rsp_valid}, 0);
        chk("rst_state_idle", 9, req_ready, 1);
        spurious = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            if (rsp_valid) spurious = 1;
        end
        slave_idle();
        arst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            if (rsp_valid) spurious = 1;
        end
        chk("rst_no_rsp", 9, spurious, 0);
        chk("rst_rdata_cleared", 9, {rsp_err, rsp_rdata}, 0);
        last_refill = '0;
        run_vec(10, vecs[2]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
